// File: rtl/reg_bank.sv
// Multi-word register store with one synchronous write port, one combinational
// read port and a one-word-per-cycle bulk-clear sweep to INIT.
module reg_bank #(
  parameter int unsigned             WIDTH = 16,
  parameter int unsigned             DEPTH = 8,
  parameter logic [WIDTH-1:0]        INIT  = '0,
  localparam int unsigned            AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [AW-1:0]    address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_n;
  logic [AW-1:0]     ptr, ptr_n;
  logic              busy_n;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  mem [DEPTH];

  // State, sweep pointer and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      busy  <= busy_n;
    end
  end

  // Next state and the single write port: user write in IDLE, INIT fill in CLEAR
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    busy_n  = busy;
    we      = 1'b0;
    waddr   = address;
    wdata   = in;
    case (state)
      IDLE: begin
        we = load;
        if (clear) begin
          state_n = CLEAR;
          ptr_n   = '0;
          busy_n  = 1'b1;
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr;
        wdata = INIT;
        ptr_n = ptr + AW'(1);
        if (ptr == AW'(DEPTH - 1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // Storage cells; reset forces zero rather than INIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign out = mem[address];

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-word register store built from load-controlled storage cells: DEPTH words of WIDTH bits, one synchronous write port, one combinational read port, and a sequenced bulk-clear that rewrites every word to a programmable INIT value, one address per cycle. It is the next-generation memory element of the memory layer: the building block for RAM-style banks and CPU register files, replacing single-bit and single-word cells.

## Interface
- WIDTH, 16, bits per word (≥1)
- DEPTH, 8, number of words (power of two, ≥2)
- INIT, 0, WIDTH-bit value written to every word by the bulk-clear sweep
- AW (derived, not overridable), clog2(DEPTH), address width
- clk  input  1  clock; all state changes on rising edge except reset
- rst_n  input  1  reset, asynchronous, active-low
- in  input  WIDTH  write data
- load  input  1  write enable; when high, `in` is captured into word `address` on the clock edge
- address  input  AW  shared read/write address
- clear  input  1  bulk-clear request, sampled on the clock edge
- out  output  WIDTH  contents of word `address` (combinational read)
- busy  output  1  high while the clear sweep is running

## Operation
- Reset (rst_n low, asynchronous): all words = 0 (not INIT), state = IDLE, sweep pointer = 0, busy = 0. Therefore `out` = 0 for every address while in reset. Reset is released synchronously to clk by the surrounding design.
- States: IDLE, CLEAR.
- Read: `out` = mem[address] continuously, in both states, with no clock dependency.
- IDLE:
  - load=1: mem[address] <= in at the edge. No other word changes.
  - clear=1: at the edge, state <= CLEAR, pointer <= 0, busy <= 1.
  - load=1 and clear=1 on the same edge: the write is performed, and the sweep starts. The written word is later overwritten by INIT.
- CLEAR, on each edge:
  - mem[pointer] <= INIT.
  - pointer <= pointer+1.
  - When pointer == DEPTH-1: that word is written, then state <= IDLE, busy <= 0, and pointer wraps to 0.
- CLEAR, requests:
  - load is ignored; the write is dropped, not queued.
  - clear is ignored; the sweep does not restart.
- Words not yet swept keep their old values. Reads during the sweep return a mix of INIT and old data, depending on pointer position.
- Reset mid-sweep: all words go to 0 immediately and busy goes to 0. The sweep is abandoned and does not resume.
- Width rules: `in`, INIT and the words are all exactly WIDTH bits with no truncation. Pointer width is AW, and its wrap after DEPTH-1 is natural.

## Timing
- Write latency:
  - load sampled at edge k; the new value is on `out` (same address) immediately after edge k.
  - Before edge k, `out` shows the old value. There is no write-through bypass.
- Clear latency:
  - clear sampled at edge k; busy=1 from edge k.
  - Word i is written at edge k+1+i.
  - busy=0 after edge k+DEPTH, so busy is high for exactly DEPTH cycles.
  - The first accepted load is at edge k+DEPTH+1 or later.
- A clear asserted in the same cycle that busy falls (sampled at edge k+DEPTH, state still CLEAR) is ignored. Callers must hold clear until busy=0 is seen.
- No combinational path from `in`/`load`/`clear` to `out` or `busy`. `address` → `out` is the only combinational path.

## Test plan
- Reset:
  - Fill words with 0xA5A5 (WIDTH=16, DEPTH=8).
  - Assert rst_n=0 between edges.
  - Required: `out`=0 at all 8 addresses immediately, with no clock edge; busy=0.
- Write/hold:
  - Write 0x1234 to addr 3.
  - Then hold `in`=0xFFFF with load=0 for 5 cycles.
  - Required: addr 3 reads 0x1234 throughout; the other addresses are unchanged.
- Sweep (INIT=0x00FF):
  - Load addr i with i+1, then pulse clear.
  - Required: busy is high for exactly 8 cycles; addr i reads 0x00FF starting the cycle after edge k+1+i, and unswept words still read i+1.
- Load during sweep:
  - At sweep cycle 2, assert load with addr 7 and 0xBEEF.
  - Required: addr 7 = INIT after the sweep, never 0xBEEF.
  - A load at the first edge after busy falls is accepted.
- Simultaneous load+clear in IDLE:
  - Write 0x5555 to addr 0 in the same cycle as clear.
  - Required: addr 0 reads 0x5555 for one cycle, then INIT after the next edge.
- Reset mid-sweep:
  - Drop rst_n at sweep cycle 4.
  - Required: busy=0 and all words=0 at once.
  - After release, the block is IDLE, and a new clear gives the full 8-cycle sweep.
